// File: rtl/posit_fft_pkg.sv
// Shared definitions for the posit FFT datapath: word width and the
// scheduler state encoding.
package posit_fft_pkg;

   localparam int POSIT_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/posit_fft_stage_sched_addr_delay.sv
// Write-back delay line: carries {valid, addr_a, addr_b} from the issue port
// to the butterfly write port, PIPE_LAT cycles later.
module fft_addr_delay
   import posit_fft_pkg::*;
#(
   parameter int LOG2N    = 3,
   parameter int PIPE_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vld_in,
   input  logic [LOG2N-1:0] a_in,
   input  logic [LOG2N-1:0] b_in,
   output logic             vld_out,
   output logic [LOG2N-1:0] a_out,
   output logic [LOG2N-1:0] b_out
);

   localparam int W = 1 + 2 * LOG2N;

   logic [W-1:0] sr_q [PIPE_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PIPE_LAT; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= {vld_in, a_in, b_in};
         for (int i = 1; i < PIPE_LAT; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign {vld_out, a_out, b_out} = sr_q[PIPE_LAT-1];

endmodule

// File: rtl/posit_fft_stage_sched.sv
// In-place radix-2 DIT FFT issue scheduler: one butterfly per cycle over all
// stages, with a drain gap per stage so write-back lands before the next stage reads.
module posit_fft_stage_sched
   import posit_fft_pkg::*;
#(
   parameter int LOG2N    = 3,
   parameter int PIPE_LAT = 2,
   localparam int SW      = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bf_valid,
   output logic             busy,
   output logic             done,
   output logic [SW-1:0]    stage,
   output logic             issue_valid,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_idx,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b,
   output logic             err
);

   localparam int JW = LOG2N - 1;
   localparam int DW = ($clog2(PIPE_LAT) < 1) ? 1 : $clog2(PIPE_LAT);
   localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
   localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

   sched_state_e     state_q, state_d;
   logic [SW-1:0]    s_q, s_d;
   logic [JW-1:0]    j_q, j_d;
   logic [DW-1:0]    dcnt_q, dcnt_d;

   logic             issue_vld_q, busy_q, done_q, err_q;
   logic [SW-1:0]    stage_q;
   logic [LOG2N-1:0] rd_a_q, rd_b_q;
   logic [JW-1:0]    tw_q;

   logic [LOG2N-1:0] a_d, b_d;
   logic [JW-1:0]    tw_d;
   logic             wr_en_w;
   logic [LOG2N-1:0] wr_a_w, wr_b_w;

   function automatic logic [LOG2N-1:0] half_of(input logic [SW-1:0] s);
      return LOG2N'(1) << s;
   endfunction

   // A address: insert a zero at bit s of j (group bits move up one place).
   function automatic logic [LOG2N-1:0] addr_a_of(input logic [SW-1:0] s,
                                                   input logic [JW-1:0] j);
      logic [LOG2N-1:0] jx, lo;
      jx = {1'b0, j};
      lo = jx & (half_of(s) - LOG2N'(1));
      return (((jx >> s) << 1) << s) | lo;
   endfunction

   function automatic logic [JW-1:0] tw_of(input logic [SW-1:0] s,
                                           input logic [JW-1:0] j);
      logic [2*LOG2N-1:0] t;
      t = {LOG2N'(0), {1'b0, j} & (half_of(s) - LOG2N'(1))};
      t = (t << (LOG2N - 1)) >> s;
      return t[JW-1:0];
   endfunction

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      j_d     = j_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         ST_IDLE: begin
            s_d    = '0;
            j_d    = '0;
            dcnt_d = '0;
            if (start) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (&j_q) begin
               state_d = ST_DRAIN;
               dcnt_d  = '0;
            end else begin
               j_d = j_q + JW'(1);
            end
         end
         ST_DRAIN: begin
            if (dcnt_q == D_LAST) begin
               if (s_q == S_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ISSUE;
                  s_d     = s_q + SW'(1);
                  j_d     = '0;
               end
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      a_d  = addr_a_of(s_d, j_d);
      b_d  = a_d + half_of(s_d);
      tw_d = tw_of(s_d, j_d);
   end

   // Outputs are registered from next-state values so they align with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         s_q         <= '0;
         j_q         <= '0;
         dcnt_q      <= '0;
         issue_vld_q <= 1'b0;
         rd_a_q      <= '0;
         rd_b_q      <= '0;
         tw_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         stage_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         j_q         <= j_d;
         dcnt_q      <= dcnt_d;
         issue_vld_q <= (state_d == ST_ISSUE);
         rd_a_q      <= (state_d == ST_ISSUE) ? a_d : '0;
         rd_b_q      <= (state_d == ST_ISSUE) ? b_d : '0;
         tw_q        <= (state_d == ST_ISSUE) ? tw_d : '0;
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= (state_d == ST_DONE);
         stage_q     <= (state_d == ST_IDLE) ? '0 : s_d;
         err_q       <= err_q | (wr_en_w & ~bf_valid);
      end
   end

   fft_addr_delay #(
      .LOG2N   (LOG2N),
      .PIPE_LAT(PIPE_LAT)
   ) u_delay (
      .clk    (clk),
      .rst    (rst),
      .vld_in (issue_vld_q),
      .a_in   (rd_a_q),
      .b_in   (rd_b_q),
      .vld_out(wr_en_w),
      .a_out  (wr_a_w),
      .b_out  (wr_b_w)
   );

   assign busy        = busy_q;
   assign done        = done_q;
   assign stage       = stage_q;
   assign issue_valid = issue_vld_q;
   assign rd_addr_a   = rd_a_q;
   assign rd_addr_b   = rd_b_q;
   assign tw_idx      = tw_q;
   assign wr_en       = wr_en_w;
   assign wr_addr_a   = wr_a_w;
   assign wr_addr_b   = wr_b_w;
   assign err         = err_q;

endmodule

// File: tb/tb_posit_fft_stage_sched.sv
// Bench for posit_fft_stage_sched: random idle gaps, stray starts and write
// faults, checked cycle by cycle against a schedule built from the FFT rules.
module tb_posit_fft_stage_sched;

   localparam int LOG2N    = 3;
   localparam int PIPE_LAT = 2;
   localparam int N        = 1 << LOG2N;
   localparam int H        = N / 2;
   localparam int SW       = 2;
   localparam int TW_W     = LOG2N - 1;

   logic             clk, rst, start, bf_valid;
   logic             busy, done, issue_valid, wr_en, err;
   logic [SW-1:0]    stage;
   logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [TW_W-1:0]  tw_idx;

   posit_fft_stage_sched #(.LOG2N(LOG2N), .PIPE_LAT(PIPE_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .bf_valid(bf_valid),
      .busy(busy), .done(done), .stage(stage), .issue_valid(issue_valid),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
      .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit err_model = 1'b0;

   // Expected behaviour per cycle, cycle 0 being the one where start is high.
   bit               m_iv[64], m_busy[64], m_done[64], m_we[64];
   logic [SW-1:0]    m_stage[64];
   logic [LOG2N-1:0] m_a[64], m_b[64], m_wa[64], m_wb[64];
   logic [TW_W-1:0]  m_tw[64];
   int               done_c;

   function automatic void build_model();
      int t;
      for (int i = 0; i < 64; i++) begin
         m_iv[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_we[i] = 0;
         m_stage[i] = '0; m_a[i] = '0; m_b[i] = '0; m_wa[i] = '0; m_wb[i] = '0; m_tw[i] = '0;
      end
      t = 1;
      for (int s = 0; s < LOG2N; s++) begin
         for (int j = 0; j < H; j++) begin
            int half, grp, pos;
            half = 1 << s;
            grp  = j / half;
            pos  = j % half;
            m_iv[t]  = 1;
            m_a[t]   = LOG2N'(grp * 2 * half + pos);
            m_b[t]   = LOG2N'(grp * 2 * half + pos + half);
            m_tw[t]  = TW_W'(pos * (H / half));
            m_we[t + PIPE_LAT] = 1;
            m_wa[t + PIPE_LAT] = m_a[t];
            m_wb[t + PIPE_LAT] = m_b[t];
            m_busy[t]  = 1;
            m_stage[t] = SW'(s);
            t++;
         end
         for (int d = 0; d < PIPE_LAT; d++) begin
            m_busy[t]  = 1;
            m_stage[t] = SW'(s);
            t++;
         end
      end
      m_busy[t]  = 1;
      m_done[t]  = 1;
      m_stage[t] = SW'(LOG2N - 1);
      done_c     = t;
   endfunction

   // One complete transform; start at cycle 0, checks cycles 1..done_c+1.
   task automatic run_transform(input int inject_c, input int extra_start_c);
      @(posedge clk); #1;
      start    = 1'b1;
      bf_valid = 1'b0;
      for (int c = 1; c <= done_c + 1; c++) begin
         @(posedge clk); #1;
         start    = (c == 5 || c == done_c || c == extra_start_c);
         bf_valid = m_we[c] ? (c != inject_c) : 1'($urandom_range(0, 1));
         @(negedge clk);
         checks++;
         if (busy !== m_busy[c]) begin
            errors++; $display("FAIL busy c=%0d got=%b exp=%b", c, busy, m_busy[c]);
         end
         checks++;
         if (done !== m_done[c]) begin
            errors++; $display("FAIL done c=%0d got=%b exp=%b", c, done, m_done[c]);
         end
         checks++;
         if (stage !== m_stage[c]) begin
            errors++; $display("FAIL stage c=%0d got=%0d exp=%0d", c, stage, m_stage[c]);
         end
         checks++;
         if (issue_valid !== m_iv[c]) begin
            errors++; $display("FAIL issue_valid c=%0d got=%b exp=%b", c, issue_valid, m_iv[c]);
         end
         if (m_iv[c]) begin
            checks++;
            if ({rd_addr_a, rd_addr_b, tw_idx} !== {m_a[c], m_b[c], m_tw[c]}) begin
               errors++;
               $display("FAIL issue_addr c=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                        c, rd_addr_a, rd_addr_b, tw_idx, m_a[c], m_b[c], m_tw[c]);
            end
         end
         checks++;
         if (wr_en !== m_we[c]) begin
            errors++; $display("FAIL wr_en c=%0d got=%b exp=%b", c, wr_en, m_we[c]);
         end
         if (m_we[c]) begin
            checks++;
            if ({wr_addr_a, wr_addr_b} !== {m_wa[c], m_wb[c]}) begin
               errors++;
               $display("FAIL wr_addr c=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                        c, wr_addr_a, wr_addr_b, m_wa[c], m_wb[c]);
            end
         end
         checks++;
         if (err !== err_model) begin
            errors++; $display("FAIL err c=%0d got=%b exp=%b", c, err, err_model);
         end
         if (m_we[c] && !bf_valid) err_model = 1'b1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({busy, done, stage, issue_valid, rd_addr_a, rd_addr_b, tw_idx,
           wr_en, wr_addr_a, wr_addr_b, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b stage=%0d iv=%b a=%0d b=%0d tw=%0d we=%b wa=%0d wb=%0d err=%b exp=all zero",
                  busy, done, stage, issue_valid, rd_addr_a, rd_addr_b, tw_idx,
                  wr_en, wr_addr_a, wr_addr_b, err);
      end
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({busy, issue_valid, wr_en, err} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b iv=%b we=%b err=%b exp=0000",
                     busy, issue_valid, wr_en, err);
         end
      end
   endtask

   task automatic test_full_run();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_transform(-1, $urandom_range(1, done_c));
   endtask

   task automatic test_back_to_back();
      run_transform(-1, $urandom_range(1, done_c));
      run_transform(-1, 0);
   endtask

   task automatic test_err_sticky();
      int k, inj, seen;
      k    = $urandom_range(0, LOG2N * H - 1);
      inj  = -1;
      seen = 0;
      for (int c = 0; c < 64; c++) begin
         if (m_we[c]) begin
            if (seen == k) inj = c;
            seen++;
         end
      end
      run_transform(inj, 0);
      run_transform(-1, 0);
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      start = 1'b1;
      for (int c = 1; c < 9; c++) begin
         @(posedge clk); #1;
         start    = 1'b0;
         bf_valid = 1'b1;
      end
      @(posedge clk); #1;
      #($urandom_range(1, 2));
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, stage, issue_valid, rd_addr_a, rd_addr_b, tw_idx,
           wr_en, wr_addr_a, wr_addr_b, err} !== '0) begin
         errors++;
         $display("FAIL async_reset got busy=%b done=%b stage=%0d iv=%b a=%0d we=%b err=%b exp=all zero",
                  busy, done, stage, issue_valid, rd_addr_a, wr_en, err);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      err_model = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         checks++;
         if ({busy, issue_valid, wr_en, done, err} !== 5'b00000) begin
            errors++;
            $display("FAIL after_abort c=%0d got busy=%b iv=%b we=%b done=%b err=%b exp=00000",
                     c, busy, issue_valid, wr_en, done, err);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      bf_valid = 1'b0;
      build_model();
      repeat (2) @(posedge clk);
      test_reset();
      test_full_run();
      test_back_to_back();
      test_err_sticky();
      test_reset_mid();
      test_full_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
